// File: rtl/rv32_alu.sv
// rtl/rv32_alu.sv - RV32I integer ALU with registered result and zero flag
//
// Purpose: execute-stage ALU. Produces a combinational 32-bit result from
// two operands and a 4-bit op ({funct7[5], funct3}), plus a one-cycle
// registered copy of the result and a registered zero flag.
//
// Ports:
//   clk     in   1   rising-edge clock for out_q / zero_q
//   reset   in   1   asynchronous active-high reset of out_q / zero_q
//   op      in   4   operation select {funct7[5], funct3}
//   a       in   32  operand A (rs1)
//   b       in   32  operand B (rs2 or immediate)
//   out     out  32  combinational result
//   out_q   out  32  out registered on rising clk
//   zero_q  out  1   registered (out == 0)

module rv32_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             zero_q
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  // RV32 shifts use only the low five bits of b; the upper bits are ignored.
  logic [4:0] shamt;
  logic       lt_signed;
  logic       lt_unsigned;

  assign shamt       = b[4:0];
  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;

  always_comb begin
    out = '0;
    unique case (op)
      OP_ADD:  out = a + b;
      OP_SUB:  out = a - b;
      OP_SLL:  out = a << shamt;
      OP_SLT:  out = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU: out = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_XOR:  out = a ^ b;
      OP_SRL:  out = a >> shamt;
      OP_SRA:  out = $unsigned($signed(a) >>> shamt);
      OP_OR:   out = a | b;
      OP_AND:  out = a & b;
      default: out = '0;
    endcase
  end

  // Reset value matches a registered zero result so branch logic sees a
  // consistent (out_q == 0, zero_q == 1) pair out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      out_q  <= out;
      zero_q <= (out == '0);
    end
  end

endmodule

// File: tb/tb_rv32_alu.sv
// tb/tb_rv32_alu.sv - self-checking bench for rv32_alu

module tb_rv32_alu;

  logic        clk;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] out;
  logic [31:0] out_q;
  logic        zero_q;

  int checks;
  int errors;

  rv32_alu #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .op     (op),
    .a      (a),
    .b      (b),
    .out    (out),
    .out_q  (out_q),
    .zero_q (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic, truncated to 32 bits.
  function automatic logic [31:0] ref_alu(input logic [3:0] f_op, input logic [31:0] fa, input logic [31:0] fb);
    longint ua, ub, sa, sb, r;
    int     sh;
    ua = longint'({32'h0, fa});
    ub = longint'({32'h0, fb});
    sa = longint'($signed(fa));
    sb = longint'($signed(fb));
    sh = int'(fb % 32);
    case (f_op)
      4'd0:    r = ua + ub;
      4'd8:    r = ua - ub;
      4'd1:    r = ua * (longint'(1) << sh);
      4'd2:    r = (sa < sb) ? 1 : 0;
      4'd3:    r = (ua < ub) ? 1 : 0;
      4'd4:    r = ua ^ ub;
      4'd5:    r = ua / (longint'(1) << sh);
      4'd13:   r = sa >>> sh;
      4'd6:    r = ua | ub;
      4'd7:    r = ua & ub;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Drive on the falling edge, check out 2 ns later (well before the next rise).
  task automatic apply_and_check(input string tag, input logic [3:0] t_op,
                                 input logic [31:0] t_a, input logic [31:0] t_b,
                                 input logic [31:0] t_exp);
    @(negedge clk);
    op = t_op;
    a  = t_a;
    b  = t_b;
    #2;
    check(tag, out, t_exp);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 63));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] exp_v;
    checks = 0;
    errors = 0;
    op     = 4'b0000;
    a      = 32'h0;
    b      = 32'h0;
    reset  = 1'b1;

    #2;
    check("reset_out_q", out_q, 32'h0);
    check("reset_zero_q", {31'h0, zero_q}, 32'h1);

    // out is independent of reset, and registers hold across an edge in reset.
    apply_and_check("out_in_reset", 4'b0000, 32'd10, 32'd20, 32'd30);
    @(posedge clk); #1;
    check("hold_out_q", out_q, 32'h0);
    check("hold_zero_q", {31'h0, zero_q}, 32'h1);

    vecs.push_back('{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000});
    vecs.push_back('{4'b1000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF});
    vecs.push_back('{4'b0000, 32'h00000005, 32'h00000003, 32'h00000008});
    vecs.push_back('{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001});
    vecs.push_back('{4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000});
    vecs.push_back('{4'b0010, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000});
    vecs.push_back('{4'b0001, 32'h00000001, 32'h0000001F, 32'h80000000});
    vecs.push_back('{4'b0001, 32'h00000001, 32'h00000020, 32'h00000001});
    vecs.push_back('{4'b0101, 32'h80000000, 32'h00000004, 32'h08000000});
    vecs.push_back('{4'b1101, 32'h80000000, 32'h00000004, 32'hF8000000});
    vecs.push_back('{4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0});
    vecs.push_back('{4'b0110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0});
    vecs.push_back('{4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000});
    vecs.push_back('{4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000});
    vecs.push_back('{4'b0101, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF});
    vecs.push_back('{4'b1101, 32'hDEADBEEF, 32'hFFFFFFE0, 32'hDEADBEEF});

    foreach (vecs[i]) begin
      apply_and_check($sformatf("dir%0d_op%04b", i, vecs[i].op),
                      vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      check($sformatf("dir%0d_model", i), ref_alu(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
    end

    // Mid-cycle reset assertion takes effect without a clock edge.
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("async_reset_out_q", out_q, 32'h0);
    check("async_reset_zero_q", {31'h0, zero_q}, 32'h1);

    apply_and_check("rel_add", 4'b0000, 32'd1, 32'd2, 32'd3);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rel_out_q", out_q, 32'd3);
    check("rel_zero_q", {31'h0, zero_q}, 32'h0);

    apply_and_check("sub_zero", 4'b1000, 32'd5, 32'd5, 32'd0);
    @(posedge clk); #1;
    check("sub_zero_q", {31'h0, zero_q}, 32'h1);
    check("sub_out_q", out_q, 32'd0);

    // Randomized: combinational and registered paths against the model.
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  r_op;
      logic [31:0] r_a, r_b;
      r_op  = 4'($urandom_range(0, 15));
      r_a   = rand_operand();
      r_b   = ($urandom_range(0, 5) == 0) ? r_a : rand_operand();
      exp_v = ref_alu(r_op, r_a, r_b);
      apply_and_check($sformatf("rnd%0d_op%04b_a%08h_b%08h", i, r_op, r_a, r_b), r_op, r_a, r_b, exp_v);
      @(posedge clk); #1;
      check($sformatf("rnd%0d_out_q", i), out_q, exp_v);
      check($sformatf("rnd%0d_zero_q", i), {31'h0, zero_q}, (exp_v == 32'h0) ? 32'h1 : 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
